// File: rtl/instr_issue_encoder.sv
// Packs decoded instruction fields into 10-bit words, queues them in a FIFO and
// issues them onto INSTR either free-running (with minimum spacing) or single-stepped.
module instr_issue_encoder #(
  parameter int DEPTH     = 8,
  parameter int ISSUE_GAP = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_in_valid,
  output logic                       o_in_ready,
  input  logic [3:0]                 i_in_funct,
  input  logic [1:0]                 i_in_rx,
  input  logic [1:0]                 i_in_ry,
  input  logic [5:0]                 i_in_imm,
  input  logic                       i_auto,
  input  logic                       i_step,
  output logic [9:0]                 o_instr,
  output logic                       o_instr_valid,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int GW = (ISSUE_GAP > 1) ? $clog2(ISSUE_GAP) : 1;
  localparam logic [GW-1:0] GAP_LOAD = GW'(ISSUE_GAP - 1);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  logic [9:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [9:0]    r_instr;
  logic          r_instr_valid;
  logic          r_step_q;
  logic          r_step_pend;
  state_t        r_state;
  logic [GW-1:0] r_gap_cnt;

  logic [9:0]    w_word;
  logic          w_full;
  logic          w_push;
  logic          w_issue;
  logic          w_step_rise;
  state_t        w_state_nxt;
  logic [GW-1:0] w_gap_nxt;

  // Codes 1100/1101 always take the immediate form, so bits [3:0] of a
  // register-form word can never hold them.
  always_comb begin
    w_word = {2'b00, i_in_rx, i_in_ry, i_in_funct};
    if (i_in_funct == 4'b1101)
      w_word = {2'b11, i_in_rx, i_in_imm};
    else if (i_in_funct == 4'b1100)
      w_word = {2'b10, i_in_rx, i_in_imm};
  end

  assign w_full      = (r_count == CW'(DEPTH));
  assign w_push      = i_in_valid && !w_full;
  assign w_step_rise = i_step && !r_step_q;

  assign o_in_ready    = !w_full;
  assign o_empty       = (r_count == '0);
  assign o_count       = r_count;
  assign o_instr       = r_instr;
  assign o_instr_valid = r_instr_valid;

  always_comb begin
    w_state_nxt = r_state;
    w_gap_nxt   = r_gap_cnt;
    w_issue     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!o_empty && (i_auto || r_step_pend)) begin
          w_issue   = 1'b1;
          w_gap_nxt = GAP_LOAD;
          if (ISSUE_GAP > 1)
            w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (r_gap_cnt <= GW'(1)) begin
          w_gap_nxt   = '0;
          w_state_nxt = S_IDLE;
        end else begin
          w_gap_nxt = r_gap_cnt - GW'(1);
        end
      end
      default: begin
        w_gap_nxt   = '0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_gap_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_gap_cnt <= w_gap_nxt;
    end
  end

  // Storage needs no reset: occupancy and pointers define what is valid.
  always_ff @(posedge i_clk) begin
    if (w_push)
      r_mem[r_wr_ptr] <= w_word;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push)
        r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_issue)
        r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_issue})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_instr       <= '0;
      r_instr_valid <= 1'b0;
    end else begin
      r_instr_valid <= w_issue;
      if (w_issue)
        r_instr <= r_mem[r_rd_ptr];
    end
  end

  // At most one outstanding step; edges arriving while one is pending are dropped.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_step_q    <= 1'b0;
      r_step_pend <= 1'b0;
    end else begin
      r_step_q <= i_step;
      if (i_auto)
        r_step_pend <= 1'b0;
      else if (w_issue)
        r_step_pend <= 1'b0;
      else if (w_step_rise)
        r_step_pend <= 1'b1;
    end
  end

endmodule

// File: tb/tb_instr_issue_encoder.sv
// Directed bench for instr_issue_encoder: a queue/cycle-stamp model is compared
// against the outputs every cycle, plus hand-computed literal expectations.
module tb_instr_issue_encoder;

  localparam int DEPTH = 8;
  localparam int GAP   = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [3:0]    in_funct = '0;
  logic [1:0]    in_rx = '0;
  logic [1:0]    in_ry = '0;
  logic [5:0]    in_imm = '0;
  logic          auto_i = 1'b0;
  logic          step = 1'b0;
  logic [9:0]    instr;
  logic          instr_valid;
  logic [CW-1:0] count;
  logic          empty;

  int total = 0;
  int bad   = 0;

  instr_issue_encoder #(.DEPTH(DEPTH), .ISSUE_GAP(GAP)) dut (
    .i_clk(clk), .i_rst(rst), .i_in_valid(in_valid), .o_in_ready(in_ready),
    .i_in_funct(in_funct), .i_in_rx(in_rx), .i_in_ry(in_ry), .i_in_imm(in_imm),
    .i_auto(auto_i), .i_step(step), .o_instr(instr), .o_instr_valid(instr_valid),
    .o_count(count), .o_empty(empty)
  );

  always #5 clk = ~clk;

  // Directed vectors with hand-packed expected words.
  logic [3:0] vf [0:8] = '{4'b0000, 4'b0001, 4'b1101, 4'b0111, 4'b1100, 4'b1010, 4'b1111, 4'b1101, 4'b0101};
  logic [1:0] vx [0:8] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd2, 2'd1, 2'd3, 2'd0};
  logic [1:0] vy [0:8] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd0, 2'd3, 2'd2, 2'd2};
  logic [5:0] vi [0:8] = '{6'h15, 6'h15, 6'h2A, 6'h15, 6'h01, 6'h15, 6'h15, 6'h3F, 6'h15};
  logic [9:0] ve [0:8] = '{10'b0000010000, 10'b0001100001, 10'b1110101010, 10'b0011110111,
                           10'b1000000001, 10'b0010001010, 10'b0001111111, 10'b1111111111,
                           10'b0000100101};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [9:0] enc(input logic [3:0] f, input logic [1:0] x, input logic [1:0] y,
                                     input logic [5:0] im);
    case (f)
      4'b1101: return {2'b11, x, im};
      4'b1100: return {2'b10, x, im};
      default: return {2'b00, x, y, f};
    endcase
  endfunction

  // Model: queue of words, issue allowed once GAP cycles have elapsed since the last one.
  logic [9:0] mq [$];
  logic [9:0] m_instr = '0;
  logic       m_valid = 1'b0;
  logic       m_pend  = 1'b0;
  logic       m_stepq = 1'b0;
  logic       m_init  = 1'b0;
  longint     cyc = 0;
  longint     last_issue = -100;

  initial forever begin
    logic rise, full, issue;
    @(posedge clk);
    cyc++;
    if (rst) begin
      mq.delete();
      m_instr = '0; m_valid = 1'b0; m_pend = 1'b0; m_stepq = 1'b0;
      last_issue = -100;
      m_init = 1'b1;
    end else begin
      rise    = step && !m_stepq;
      m_stepq = step;
      full    = (mq.size() == DEPTH);
      issue   = (mq.size() != 0) && (cyc - last_issue >= GAP) && (auto_i || m_pend);
      m_valid = issue;
      if (issue) begin
        m_instr    = mq.pop_front();
        last_issue = cyc;
      end
      if (auto_i)     m_pend = 1'b0;
      else if (issue) m_pend = 1'b0;
      else if (rise)  m_pend = 1'b1;
      if (in_valid && !full)
        mq.push_back(enc(in_funct, in_rx, in_ry, in_imm));
    end
  end

  initial forever begin
    @(negedge clk);
    if (m_init) begin
      chk("instr", 32'(instr), 32'(m_instr));
      chk("instr_valid", 32'(instr_valid), 32'(m_valid));
      chk("count", 32'(count), 32'(mq.size()));
      chk("empty", 32'(empty), 32'(mq.size() == 0));
      chk("in_ready", 32'(in_ready), 32'(mq.size() != DEPTH));
    end
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic drive(input logic [3:0] f, input logic [1:0] x, input logic [1:0] y, input logic [5:0] im);
    in_funct = f; in_rx = x; in_ry = y; in_imm = im; in_valid = 1'b1;
  endtask

  task automatic push1(input logic [3:0] f, input logic [1:0] x, input logic [1:0] y, input logic [5:0] im);
    drive(f, x, y, im);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic pushv(input int k);
    push1(vf[k], vx[k], vy[k], vi[k]);
  endtask

  task automatic wait_valid(input string nm, input logic [9:0] exp, input int lim);
    bit found = 0;
    for (int n = 0; n < lim && !found; n++) begin
      @(negedge clk);
      if (instr_valid) begin
        chk(nm, 32'(instr), 32'(exp));
        found = 1;
      end
    end
    if (!found) begin
      total++; bad++;
      $display("FAIL %s: no INSTR_VALID within %0d cycles, expected word %0h", nm, lim, exp);
    end
  endtask

  task automatic count_pulses(input int n, output int p);
    p = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (instr_valid) p++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int p;
    int npulse;
    longint prev_t;
    // reset state
    tick(); tick();
    @(negedge clk);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_instr", 32'(instr), 32'd0);
    tick();
    rst = 1'b0;

    // register and immediate encodings, AUTO=1
    auto_i = 1'b1;
    push1(4'b0011, 2'd2, 2'd1, 6'h3F);
    wait_valid("enc_reg", 10'b0010010011, 10);
    repeat (5) tick();
    push1(4'b1101, 2'd3, 2'd2, 6'd37);
    wait_valid("enc_imm1101", 10'b1111100101, 10);
    repeat (5) tick();
    push1(4'b1100, 2'd1, 2'd2, 6'd5);
    wait_valid("enc_imm1100", 10'b1001000101, 10);
    repeat (5) tick();

    // fill to full in step mode, then free-run with spacing
    auto_i = 1'b0;
    tick();
    for (int k = 0; k < 9; k++) begin
      drive(vf[k], vx[k], vy[k], vi[k]);
      tick();
    end
    tick();
    @(negedge clk);
    chk("full_count", 32'(count), 32'd8);
    chk("full_ready", 32'(in_ready), 32'd0);
    tick();
    auto_i = 1'b1; in_valid = 1'b0;
    npulse = 0; prev_t = 0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (instr_valid) begin
        if (npulse < 8) chk("full_order", 32'(instr), 32'(ve[npulse]));
        if (npulse == 0) chk("ready_after_pop", 32'(in_ready), 32'd1);
        else chk("gap_spacing", 32'(cyc - prev_t), 32'(GAP));
        prev_t = cyc;
        npulse++;
      end
    end
    chk("full_pulses", 32'(npulse), 32'd8);

    // step mode
    auto_i = 1'b0;
    tick();
    pushv(0); pushv(1); pushv(2);
    step = 1'b1; tick(); step = 1'b0;
    wait_valid("step_issue1", ve[0], 10);
    step = 1'b1; @(negedge clk);
    step = 1'b0; @(negedge clk);
    step = 1'b1; @(negedge clk);
    step = 1'b0;
    count_pulses(20, p);
    chk("step_double_edge", 32'(p), 32'd1);
    step = 1'b1; @(negedge clk); step = 1'b0;
    wait_valid("step_issue3", ve[2], 10);
    step = 1'b1; @(negedge clk); step = 1'b0;
    count_pulses(8, p);
    chk("step_empty_none", 32'(p), 32'd0);
    pushv(3);
    @(negedge clk);
    chk("step_nobypass", 32'(instr_valid), 32'd0);
    @(negedge clk);
    chk("step_after_push_v", 32'(instr_valid), 32'd1);
    chk("step_after_push_w", 32'(instr), 32'(ve[3]));

    // simultaneous push/pop with COUNT=4, then pointer wrap
    repeat (6) tick();
    pushv(0); pushv(1); pushv(2); pushv(3);
    drive(vf[4], vx[4], vy[4], vi[4]);
    auto_i = 1'b1;
    tick();
    auto_i = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("simul_count", 32'(count), 32'd4);
    chk("simul_word", 32'(instr), 32'(ve[0]));
    tick();
    auto_i = 1'b1;
    wait_valid("simul_next", ve[1], 10);
    repeat (20) tick();
    for (int i = 0; i < 20; i++) begin
      drive(4'(i), 2'(i), 2'(i + 1), 6'(i * 3));
      tick();
    end
    in_valid = 1'b0;
    repeat (45) tick();
    chk("wrap_drained", 32'(empty), 32'd1);

    // reset mid-operation
    auto_i = 1'b0;
    tick();
    for (int k = 0; k < 6; k++) pushv(k);
    step = 1'b1; tick(); step = 1'b0;
    wait_valid("rst_pre_issue", ve[0], 10);
    step = 1'b1; rst = 1'b1;
    @(negedge clk);
    chk("midrst_count", 32'(count), 32'd0);
    chk("midrst_instr", 32'(instr), 32'd0);
    chk("midrst_valid", 32'(instr_valid), 32'd0);
    chk("midrst_empty", 32'(empty), 32'd1);
    step = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    count_pulses(8, p);
    chk("postrst_idle", 32'(p), 32'd0);
    pushv(1);
    count_pulses(10, p);
    chk("postrst_nostep", 32'(p), 32'd0);
    step = 1'b1; tick(); step = 1'b0;
    wait_valid("postrst_step", ve[1], 10);
    repeat (6) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
